// File: rtl/xalu_nibble_seq.sv
// xalu_nibble_seq: nibble-serial ALU sequencer driving an external 4-bit slice.
// Define XALU_SEQ_NEGZERO_EN to enable the res_negzero (all-ones result) flag.
module xalu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic [2:0]           op_f,
  input  logic                 op_com,
  input  logic                 op_cin,
  input  logic                 op_valid,
  output logic                 op_ready,
  output logic [3:0]           sl_a,
  output logic [3:0]           sl_b,
  output logic [2:0]           sl_f,
  output logic                 sl_com,
  output logic                 sl_ci_right,
  output logic                 sl_ci_left,
  input  logic [3:0]           sl_d,
  input  logic                 sl_co_left,
  input  logic                 sl_co_right,
  input  logic                 sl_equ,
  output logic [4*NIBBLES-1:0] res,
  output logic                 res_cout,
  output logic                 res_zero,
  output logic                 res_negzero,
  output logic                 res_equ,
  output logic                 res_valid,
  input  logic                 res_ready
);
  localparam int W  = 4*NIBBLES;
  localparam int IW = $clog2(NIBBLES+1);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t         state_q;
  logic [W-1:0]   a_q, b_q, res_q;
  logic [2:0]     f_q;
  logic           com_q, cin_q, carry_q, eq_acc_q, cout_q, zero_q, equ_q;
  logic [IW-1:0]  idx_q, pos;
  logic [IW+1:0]  bit_pos;
  logic           shr, busy, ci;
  assign shr     = f_q == 3'd6;
  // ISSUE runs one extra cycle after the last nibble to fold the result flags.
  assign busy    = state_q == ISSUE && idx_q != IW'(NIBBLES);
  assign pos     = shr ? IW'(NIBBLES-1) - idx_q : idx_q;
  assign bit_pos = {pos, 2'b00};
  assign ci      = idx_q == '0 ? cin_q : carry_q;
  assign sl_a        = busy ? 4'(a_q >> bit_pos) : 4'd0;
  assign sl_b        = busy ? 4'(b_q >> bit_pos) : 4'd0;
  assign sl_f        = busy ? f_q : 3'd0;
  assign sl_com      = busy & com_q;
  assign sl_ci_right = busy & ~shr & ci;
  assign sl_ci_left  = busy & shr & ci;
  assign op_ready  = state_q == IDLE;
  assign res_valid = state_q == DONE;
  assign res       = res_q;
  assign res_cout  = cout_q;
  assign res_zero  = zero_q;
  assign res_equ   = equ_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      com_q    <= 1'b0;
      cin_q    <= 1'b0;
      idx_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      eq_acc_q <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      equ_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (op_valid) begin
          state_q  <= ISSUE;
          a_q      <= op_a;
          b_q      <= op_b;
          f_q      <= op_f;
          com_q    <= op_com;
          cin_q    <= op_cin;
          idx_q    <= '0;
          res_q    <= '0;
          eq_acc_q <= 1'b1;
          cout_q   <= 1'b0;
          zero_q   <= 1'b0;
          equ_q    <= 1'b0;
        end
        ISSUE: if (busy) begin
          res_q    <= (res_q & ~(W'(15) << bit_pos)) | (W'(sl_d) << bit_pos);
          carry_q  <= shr ? sl_co_right : sl_co_left;
          eq_acc_q <= eq_acc_q & sl_equ;
          idx_q    <= idx_q + 1'b1;
        end else begin
          state_q <= DONE;
          cout_q  <= carry_q & (f_q == 3'd0 || f_q == 3'd6 || f_q == 3'd7);
          zero_q  <= res_q == '0;
          equ_q   <= eq_acc_q;
        end
        DONE: if (res_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef XALU_SEQ_NEGZERO_EN
  logic nz_q;
  always_ff @(posedge clk)
    nz_q <= rst || (state_q == IDLE && op_valid) ? 1'b0 :
            state_q == ISSUE && !busy ? &res_q : nz_q;
  assign res_negzero = nz_q;
`else
  assign res_negzero = 1'b0;
`endif
endmodule

// File: tb/tb_xalu_nibble_seq.sv
// tb_xalu_nibble_seq: directed and random checks of xalu_nibble_seq against a word-level model.
module tb_xalu_nibble_seq;
  localparam int NIBBLES = 4;
  localparam int W = 4*NIBBLES;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [2:0] op_f = '0;
  logic op_com = 1'b0, op_cin = 1'b0, op_valid = 1'b0, op_ready;
  logic [3:0] sl_a, sl_b, sl_d;
  logic [2:0] sl_f;
  logic sl_com, sl_ci_right, sl_ci_left, sl_co_left, sl_co_right, sl_equ;
  logic [W-1:0] res;
  logic res_cout, res_zero, res_negzero, res_equ, res_valid, res_ready = 1'b0;
  int n_cmp = 0, n_err = 0;
  logic [3:0] cil_v;
  logic [4:0] st;

  always #5 clk = ~clk;

  xalu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .op_f(op_f), .op_com(op_com),
    .op_cin(op_cin), .op_valid(op_valid), .op_ready(op_ready), .sl_a(sl_a), .sl_b(sl_b),
    .sl_f(sl_f), .sl_com(sl_com), .sl_ci_right(sl_ci_right), .sl_ci_left(sl_ci_left),
    .sl_d(sl_d), .sl_co_left(sl_co_left), .sl_co_right(sl_co_right), .sl_equ(sl_equ),
    .res(res), .res_cout(res_cout), .res_zero(res_zero), .res_negzero(res_negzero),
    .res_equ(res_equ), .res_valid(res_valid), .res_ready(res_ready)
  );

  // Behavioural 4-bit slice
  always_comb begin
    st = '0;
    sl_co_right = 1'b0;
    case (sl_f)
      3'd0: st = {1'b0, sl_a} + {1'b0, sl_b} + 5'(sl_ci_right);
      3'd1: st = {1'b0, sl_a & sl_b};
      3'd2: st = {1'b0, sl_a | sl_b};
      3'd3: st = {1'b0, sl_a ^ sl_b};
      3'd4: st = {1'b0, sl_a};
      3'd5: st = {1'b0, sl_b};
      3'd6: begin st = {1'b0, sl_ci_left, sl_a[3:1]}; sl_co_right = sl_a[0]; end
      default: st = {sl_a, sl_ci_right};
    endcase
    sl_d = sl_com ? ~st[3:0] : st[3:0];
    sl_co_left = st[4];
    sl_equ = sl_a == sl_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, b, input logic [2:0] f,
                                input logic com, cin, output logic [W-1:0] r, output logic c);
    logic [W:0] s;
    case (f)
      3'd0: s = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      3'd1: s = {1'b0, a & b};
      3'd2: s = {1'b0, a | b};
      3'd3: s = {1'b0, a ^ b};
      3'd4: s = {1'b0, a};
      3'd5: s = {1'b0, b};
      3'd6: s = {a[0], cin, a[W-1:1]};
      default: s = {a, cin};
    endcase
    r = com ? ~s[W-1:0] : s[W-1:0];
    c = s[W];
  endfunction

  task automatic run_op(input logic [W-1:0] a, b, input logic [2:0] f,
                        input logic com, cin, input int hold);
    logic [W-1:0] er;
    logic ec;
    int lat;
    model(a, b, f, com, cin, er, ec);
    chk("op_ready_idle", 32'(op_ready), 32'd1);
    op_a = a; op_b = b; op_f = f; op_com = com; op_cin = cin; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); op_f = 3'($urandom); op_com = 1'($urandom); op_cin = 1'($urandom);
    lat = 0;
    cil_v = '0;
    while (!res_valid && lat < 20) begin
      if (lat < NIBBLES) cil_v = {cil_v[2:0], sl_ci_left};
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(NIBBLES+1));
    chk("res", 32'(res), 32'(er));
    chk("res_cout", 32'(res_cout), 32'(ec));
    chk("res_zero", 32'(res_zero), 32'(er == '0));
    chk("res_equ", 32'(res_equ), 32'(a == b));
`ifdef XALU_SEQ_NEGZERO_EN
    chk("res_negzero", 32'(res_negzero), 32'(&er));
`else
    chk("res_negzero", 32'(res_negzero), 32'd0);
`endif
    for (int i = 0; i < hold; i++) begin
      op_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_res", 32'(res), 32'(er));
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_op_ready", 32'(op_ready), 32'd0);
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("post_hs_op_ready", 32'(op_ready), 32'd1);
    chk("post_hs_valid", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_outs", {res, res_cout, res_zero, res_negzero, res_equ, res_valid}, 32'd0);
    chk("rst_sl", {sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left}, 32'd0);
    run_op(16'hFFFF, 16'h0001, 3'd0, 1'b0, 1'b0, 0);
    run_op(16'h8001, 16'h0000, 3'd6, 1'b0, 1'b1, 0);
    chk("shr_ci_left_seq", 32'(cil_v), 32'b1000);
    run_op(16'h8001, 16'h0000, 3'd7, 1'b0, 1'b0, 1);
    run_op(16'h1234, 16'h1234, 3'd3, 1'b0, 1'b0, 0);
    run_op(16'h0000, 16'h5A5A, 3'd4, 1'b1, 1'b0, 2);
    run_op(16'hA5C3, 16'h0F0F, 3'd1, 1'b0, 1'b0, 10);
    // Reset in the second ISSUE cycle aborts the operation
    op_a = 16'h1111; op_b = 16'h2222; op_f = 3'd0; op_valid = 1'b1;
    @(posedge clk); #1 op_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_op_ready", 32'(op_ready), 32'd1);
    chk("abort_outs", {res, res_cout, res_zero, res_negzero, res_equ, res_valid}, 32'd0);
    chk("abort_sl", {sl_a, sl_b, sl_f, sl_com, sl_ci_right, sl_ci_left}, 32'd0);
    run_op(16'h0003, 16'h0004, 3'd0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_op(ra, rb, 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
